// File: rtl/cd_abus_regs.sv
// CD-block host register window on the SCU A-bus (CS2): HIRQ/HIRQMASK, CR1-CR4
// command/response pair, host interrupt and a DTR read FIFO fed by a pattern fill engine.
module cd_abus_regs #(
  parameter int RESP_LAT = 64,
  parameter int FIFO_AW  = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        CE,
  input  logic [25:0] AA,
  input  logic [15:0] DI,
  output logic [15:0] DO,
  input  logic        ACS2_N,
  input  logic        ARD_N,
  input  logic        AWRU_N,
  input  logic        AWRL_N,
  output logic        AWAIT_N,
  output logic        AIRQ_N
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = FIFO_AW + 1;
  localparam int LW    = (RESP_LAT < 2) ? 1 : $clog2(RESP_LAT + 1);

  localparam logic [CW-1:0]      DEPTH_L = CW'(DEPTH);
  localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);
  localparam logic [LW-1:0]      LAT_L   = LW'(RESP_LAT);
  localparam logic [LW-1:0]      LAT_ONE = LW'(1);

  localparam logic [15:0] OFF_DTR  = 16'h0000;
  localparam logic [15:0] OFF_HIRQ = 16'h0008;
  localparam logic [15:0] OFF_MASK = 16'h000C;
  localparam logic [15:0] OFF_CR1  = 16'h0018;
  localparam logic [15:0] OFF_CR2  = 16'h001C;
  localparam logic [15:0] OFF_CR3  = 16'h0020;
  localparam logic [15:0] OFF_CR4  = 16'h0024;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  localparam logic [1:0] KIND_GET  = 2'd0;
  localparam logic [1:0] KIND_FILL = 2'd1;
  localparam logic [1:0] KIND_ERR  = 2'd2;

  function automatic logic [15:0] merge_lanes(input logic [15:0] old_v, input logic [15:0] new_v,
                                               input logic [15:0] lane_m);
    return (old_v & ~lane_m) | (new_v & lane_m);
  endfunction

  logic        ard_q_r, awru_q_r, awrl_q_r;
  logic [15:0] do_r;
  logic        await_n_r, airq_n_r, pend_r;
  logic [2:0]  hirq_r;
  logic [15:0] mask_r;
  logic [15:0] cmd1_r, cmd2_r, cmd3_r, cmd4_r;
  logic [15:0] rsp1_r, rsp2_r, rsp3_r, rsp4_r;
  logic [0:0]  state_r;
  logic [LW-1:0] cnt_r;
  logic [1:0]  kind_r;
  logic        fill_active_r;
  logic [7:0]  fill_rem_r, rsp_n_r;
  logic [15:0] fill_val_r, rsp_v_r;
  logic [15:0] mem_r [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_r, rd_ptr_r;
  logic [CW-1:0] count_r;

  logic        sel_s, rd_fire_s, wr_fire_s, trig_s, start_fill_s, post_s;
  logic        push_s, pop_s, fifo_empty_s, fifo_full_s, dend_set_s, drdy_set_s;
  logic [15:0] off_s, lane_m_s, head_s, do_next_s;
  logic        await_next_s, pend_next_s;
  logic [2:0]  hirq_clr_s, hirq_next_s;
  logic [7:0]  stat_s;
  logic        unused_s;

  assign sel_s        = ~ACS2_N && (AA[25:16] == 10'h189);
  assign off_s        = {AA[15:1], 1'b0};
  assign rd_fire_s    = CE && sel_s && ~ARD_N && ard_q_r;
  assign wr_fire_s    = CE && sel_s && ((~AWRU_N && awru_q_r) || (~AWRL_N && awrl_q_r));
  assign lane_m_s     = {{8{~AWRU_N}}, {8{~AWRL_N}}};
  assign trig_s       = wr_fire_s && (off_s == OFF_CR4) && (state_r == ST_IDLE);
  assign start_fill_s = trig_s && (cmd1_r[15:8] == 8'h60) && !fill_active_r;
  assign post_s       = CE && (state_r == ST_BUSY) && (cnt_r <= LAT_ONE);
  assign fifo_empty_s = (count_r == {CW{1'b0}});
  assign fifo_full_s  = (count_r == DEPTH_L);
  assign head_s       = mem_r[rd_ptr_r];
  assign push_s       = CE && fill_active_r && (fill_rem_r != 8'h00) && !fifo_full_s;
  assign dend_set_s   = CE && fill_active_r && ((fill_rem_r == 8'h00) || (push_s && (fill_rem_r == 8'h01)));
  assign drdy_set_s   = push_s && fifo_empty_s;
  assign stat_s       = fill_active_r ? 8'h01 : 8'h00;
  assign unused_s     = ^{AA[0], cmd1_r[7:0], cmd2_r[15:8], cmd4_r};

  // Internal sets win over the write-0-to-clear mask; a trigger drops CMOK.
  assign hirq_clr_s  = (wr_fire_s && (off_s == OFF_HIRQ) && ~AWRL_N) ? DI[2:0] : 3'b111;
  assign hirq_next_s = (hirq_r & hirq_clr_s & {2'b11, ~trig_s}) | {dend_set_s, drdy_set_s, post_s};

  // Read data path: a pending DTR wait takes priority over any new read fire.
  always_comb begin
    do_next_s    = do_r;
    await_next_s = await_n_r;
    pend_next_s  = pend_r;
    pop_s        = 1'b0;
    if (CE && pend_r) begin
      if (!fifo_empty_s) begin
        do_next_s    = head_s;
        pop_s        = 1'b1;
        await_next_s = 1'b1;
        pend_next_s  = 1'b0;
      end else begin
        await_next_s = 1'b0;
      end
    end else if (rd_fire_s) begin
      case (off_s)
        OFF_DTR: begin
          if (!fifo_empty_s) begin
            do_next_s = head_s;
            pop_s     = 1'b1;
          end else if (fill_active_r) begin
            await_next_s = 1'b0;
            pend_next_s  = 1'b1;
          end else begin
            do_next_s = 16'h0000;
          end
        end
        OFF_HIRQ: do_next_s = {13'h0000, hirq_r};
        OFF_MASK: do_next_s = mask_r;
        OFF_CR1:  do_next_s = rsp1_r;
        OFF_CR2:  do_next_s = rsp2_r;
        OFF_CR3:  do_next_s = rsp3_r;
        OFF_CR4:  do_next_s = rsp4_r;
        default:  do_next_s = 16'h0000;
      endcase
    end else begin
      pop_s = 1'b0;
    end
  end

  // Strobe history, read outputs, HIRQ and the interrupt line.
  always_ff @(posedge CLK) begin
    if (RST) begin
      ard_q_r   <= 1'b1;
      awru_q_r  <= 1'b1;
      awrl_q_r  <= 1'b1;
      do_r      <= 16'h0000;
      await_n_r <= 1'b1;
      pend_r    <= 1'b0;
      hirq_r    <= 3'b001;
      airq_n_r  <= 1'b1;
    end else if (CE) begin
      ard_q_r   <= ARD_N;
      awru_q_r  <= AWRU_N;
      awrl_q_r  <= AWRL_N;
      do_r      <= do_next_s;
      await_n_r <= await_next_s;
      pend_r    <= pend_next_s;
      hirq_r    <= hirq_next_s;
      airq_n_r  <= ~|({13'h0000, hirq_r} & mask_r);
    end else begin
      do_r <= do_r;
    end
  end

  // Host-writable latches: HIRQMASK and CMD1-CMD4, byte-lane merged.
  always_ff @(posedge CLK) begin
    if (RST) begin
      mask_r <= 16'h0000;
      cmd1_r <= 16'h0000;
      cmd2_r <= 16'h0000;
      cmd3_r <= 16'h0000;
      cmd4_r <= 16'h0000;
    end else if (wr_fire_s) begin
      case (off_s)
        OFF_MASK: mask_r <= merge_lanes(mask_r, DI, lane_m_s);
        OFF_CR1:  cmd1_r <= merge_lanes(cmd1_r, DI, lane_m_s);
        OFF_CR2:  cmd2_r <= merge_lanes(cmd2_r, DI, lane_m_s);
        OFF_CR3:  cmd3_r <= merge_lanes(cmd3_r, DI, lane_m_s);
        OFF_CR4:  cmd4_r <= merge_lanes(cmd4_r, DI, lane_m_s);
        default:  mask_r <= mask_r;
      endcase
    end else begin
      mask_r <= mask_r;
    end
  end

  // Command engine: the outcome class is fixed at trigger, STAT is sampled at post.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
      cnt_r   <= {LW{1'b0}};
      kind_r  <= KIND_GET;
    end else if (CE) begin
      case (state_r)
        ST_IDLE: begin
          if (trig_s) begin
            state_r <= ST_BUSY;
            cnt_r   <= LAT_L;
            if (cmd1_r[15:8] == 8'h00)  kind_r <= KIND_GET;
            else if (start_fill_s)      kind_r <= KIND_FILL;
            else                        kind_r <= KIND_ERR;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (cnt_r <= LAT_ONE) state_r <= ST_IDLE;
          else                  cnt_r   <= cnt_r - LAT_ONE;
        end
        default: state_r <= ST_IDLE;
      endcase
    end else begin
      state_r <= state_r;
    end
  end

  // Response registers, loaded once per command when it is posted.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rsp1_r <= 16'h0043;
      rsp2_r <= 16'h4442;
      rsp3_r <= 16'h4C4F;
      rsp4_r <= 16'h434B;
    end else if (post_s) begin
      case (kind_r)
        KIND_GET: begin
          rsp1_r <= {stat_s, 8'h00};
          rsp2_r <= 16'h0000;
          rsp3_r <= 16'h0000;
        end
        KIND_FILL: begin
          rsp1_r <= {stat_s, 8'h00};
          rsp2_r <= {8'h00, rsp_n_r};
          rsp3_r <= rsp_v_r;
        end
        default: begin
          rsp1_r <= 16'hFF00;
          rsp2_r <= 16'h0000;
          rsp3_r <= 16'h0000;
        end
      endcase
      rsp4_r <= 16'h0000;
    end else begin
      rsp1_r <= rsp1_r;
    end
  end

  // Fill engine: one incrementing word per CE cycle, stalled while the FIFO is full.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fill_active_r <= 1'b0;
      fill_rem_r    <= 8'h00;
      fill_val_r    <= 16'h0000;
      rsp_n_r       <= 8'h00;
      rsp_v_r       <= 16'h0000;
    end else if (CE) begin
      if (start_fill_s) begin
        fill_active_r <= 1'b1;
        fill_rem_r    <= cmd2_r[7:0];
        fill_val_r    <= cmd3_r;
        rsp_n_r       <= cmd2_r[7:0];
        rsp_v_r       <= cmd3_r;
      end else if (dend_set_s) begin
        fill_active_r <= 1'b0;
        fill_rem_r    <= 8'h00;
        fill_val_r    <= fill_val_r + 16'h0001;
      end else if (push_s) begin
        fill_rem_r <= fill_rem_r - 8'h01;
        fill_val_r <= fill_val_r + 16'h0001;
      end else begin
        fill_rem_r <= fill_rem_r;
      end
    end else begin
      fill_rem_r <= fill_rem_r;
    end
  end

  // FIFO pointers and occupancy; pops only happen when non-empty.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_ptr_r <= {FIFO_AW{1'b0}};
      rd_ptr_r <= {FIFO_AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else if (CE) begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      else        wr_ptr_r <= wr_ptr_r;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      else        rd_ptr_r <= rd_ptr_r;
      count_r <= count_r + CW'(push_s) - CW'(pop_s);
    end else begin
      count_r <= count_r;
    end
  end

  // FIFO storage.
  always_ff @(posedge CLK) begin
    if (push_s) mem_r[wr_ptr_r] <= fill_val_r;
  end

  assign DO      = do_r;
  assign AWAIT_N = await_n_r;
  assign AIRQ_N  = airq_n_r;

endmodule
